// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
//   arb_state_e : arbiter FSM state (idle / channel granted)
//   id_width()  : channel-tag width, never less than one bit
//   rr_pick()   : one-hot round-robin winner, scanning upward from last+1
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } arb_state_e;

  // Widest channel vector rr_pick() can handle.
  localparam int unsigned MaxCh  = 32;
  localparam int unsigned MaxChW = $clog2(MaxCh);

  function automatic int unsigned id_width(input int unsigned ch_num);
    return (ch_num <= 2) ? 1 : $clog2(ch_num);
  endfunction

  // First set bit of req, scanning last+1, last+2, ... modulo ch_num.
  // The channel at index 'last' is reached last, so it gets the lowest priority.
  function automatic logic [MaxCh-1:0] rr_pick(input logic [MaxCh-1:0] req,
                                               input int unsigned      last,
                                               input int unsigned      ch_num);
    logic [MaxCh-1:0]  win;
    logic              found;
    logic [MaxChW-1:0] idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MaxCh; i++) begin
      idx = MaxChW'((last + i) % ch_num);
      if (!found && (i <= ch_num) && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/sc_fifo.sv
// Single-clock show-ahead FIFO with a registered output stage.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   wr_i/wr_data_i : push a word (accepted when not full, or when popping)
//   rd_i           : pop the head word (ignored while empty_o)
//   rd_data_o      : head word, valid while empty_o=0
//   empty_o/full_o : status flags
//   used_words_o   : stored words, output register included
// A word written into an empty FIFO reaches the output register one edge later.
// When the only stored word is popped in the same cycle as a write, the new
// word is loaded straight into the output register so empty_o never blinks.
module sc_fifo #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned WORDS_AMOUNT = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            wr_i,
  input  logic [DATA_WIDTH-1:0]           wr_data_i,
  input  logic                            rd_i,
  output logic [DATA_WIDTH-1:0]           rd_data_o,
  output logic                            empty_o,
  output logic                            full_o,
  output logic [$clog2(WORDS_AMOUNT):0]   used_words_o
);

  localparam int unsigned     AddrW = $clog2(WORDS_AMOUNT);
  localparam logic [AddrW:0]  Cap   = (AddrW + 1)'(WORDS_AMOUNT);
  localparam logic [AddrW:0]  One   = (AddrW + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [WORDS_AMOUNT];
  logic [AddrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]        mem_cnt_q, mem_cnt_d;
  logic [AddrW:0]        used_q, used_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  out_valid_q, out_valid_d;

  logic full, pop, push, bypass, mem_wr, load;

  assign full   = (used_q == Cap);
  assign pop    = rd_i & out_valid_q;
  assign push   = wr_i & (~full | pop);
  assign bypass = push & pop & (mem_cnt_q == '0);
  assign mem_wr = push & ~bypass;
  // Refill the output register whenever it is free or being consumed.
  assign load   = (~out_valid_q | pop) & (mem_cnt_q != '0);

  always_comb begin
    mem_cnt_d = mem_cnt_q;
    case ({mem_wr, load})
      2'b10:   mem_cnt_d = mem_cnt_q + One;
      2'b01:   mem_cnt_d = mem_cnt_q - One;
      default: mem_cnt_d = mem_cnt_q;
    endcase
  end

  always_comb begin
    used_d = used_q;
    case ({push, pop})
      2'b10:   used_d = used_q + One;
      2'b01:   used_d = used_q - One;
      default: used_d = used_q;
    endcase
  end

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (bypass) begin
      out_d       = wr_data_i;
      out_valid_d = 1'b1;
    end else if (load) begin
      out_d       = mem[rd_ptr_q];
      out_valid_d = 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      used_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (mem_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (load)   rd_ptr_q <= rd_ptr_q + 1'b1;
      mem_cnt_q   <= mem_cnt_d;
      used_q      <= used_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage array is not reset; its contents are meaningless until written.
  always_ff @(posedge clk_i) begin
    if (mem_wr) mem[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o    = out_q;
  assign empty_o      = ~out_valid_q;
  assign full_o       = full;
  assign used_words_o = used_q;

endmodule

// File: rtl/rr_fifo_wr_arbiter.sv
// Round-robin write arbiter: CH_NUM producers share one sc_fifo write port.
// A granted channel keeps the port for up to BURST_LEN words; every stored
// word carries its source channel ID in the MSBs.
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   ch_valid_i/ch_data_i : per-channel request and payload
//   ch_ready_o           : per-channel accept (grant and not full)
//   grant_o              : one-hot current owner, zero when idle
//   rd_i                 : pop the head word
//   rd_data_o/rd_ch_o    : head word payload and source channel
//   empty_o/full_o       : FIFO status
//   used_words_o         : FIFO fill level
module rr_fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned CH_NUM       = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned WORDS_AMOUNT = 16,
  parameter int unsigned BURST_LEN    = 4,
  parameter int unsigned ID_WIDTH     = id_width(CH_NUM)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [CH_NUM-1:0]              ch_valid_i,
  input  logic [CH_NUM*DATA_WIDTH-1:0]   ch_data_i,
  output logic [CH_NUM-1:0]              ch_ready_o,
  output logic [CH_NUM-1:0]              grant_o,
  input  logic                           rd_i,
  output logic [DATA_WIDTH-1:0]          rd_data_o,
  output logic [ID_WIDTH-1:0]            rd_ch_o,
  output logic                           empty_o,
  output logic                           full_o,
  output logic [$clog2(WORDS_AMOUNT):0]  used_words_o
);

  localparam int unsigned         CntW       = $clog2(BURST_LEN + 1);
  localparam logic [CntW-1:0]     LastBeat   = CntW'(BURST_LEN - 1);
  localparam logic [CntW-1:0]     CntOne     = CntW'(1);
  // Channel 0 must win the first arbitration after reset.
  localparam logic [ID_WIDTH-1:0] ResetOwner = ID_WIDTH'(CH_NUM - 1);

  arb_state_e            state_q, state_d;
  logic [CH_NUM-1:0]     grant_q, grant_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]   last_q, last_d;

  logic [ID_WIDTH-1:0]   owner;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  owner_valid;
  logic                  xfer;
  logic                  fifo_full;
  logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_rd_word;

  // Owner index and payload mux from the one-hot grant.
  always_comb begin
    owner      = '0;
    owner_data = '0;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      if (grant_q[c]) begin
        owner      = ID_WIDTH'(c);
        owner_data = ch_data_i[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Ready depends only on registered state, never on ch_valid_i.
  assign ch_ready_o  = grant_q & {CH_NUM{~fifo_full}};
  assign xfer        = |(ch_valid_i & ch_ready_o);
  assign owner_valid = |(ch_valid_i & grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (|ch_valid_i) begin
          grant_d = CH_NUM'(rr_pick(MaxCh'(ch_valid_i), 32'(last_q), CH_NUM));
          cnt_d   = '0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        // While full no transfer happens, so the count and grant simply hold.
        if (xfer) cnt_d = cnt_q + CntOne;
        if (!owner_valid || (xfer && (cnt_q == LastBeat))) begin
          last_d = owner;
          cnt_d  = '0;
          if (|ch_valid_i) begin
            // Scan starts after the old owner, which therefore ranks last.
            grant_d = CH_NUM'(rr_pick(MaxCh'(ch_valid_i), 32'(owner), CH_NUM));
            state_d = StGrant;
          end else begin
            grant_d = '0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        grant_d = '0;
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      grant_q <= '0;
      cnt_q   <= '0;
      last_q  <= ResetOwner;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  sc_fifo #(
    .DATA_WIDTH   (ID_WIDTH + DATA_WIDTH),
    .WORDS_AMOUNT (WORDS_AMOUNT)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wr_i         (xfer),
    .wr_data_i    ({owner, owner_data}),
    .rd_i         (rd_i),
    .rd_data_o    (fifo_rd_word),
    .empty_o      (empty_o),
    .full_o       (fifo_full),
    .used_words_o (used_words_o)
  );

  assign grant_o              = grant_q;
  assign full_o               = fifo_full;
  assign {rd_ch_o, rd_data_o} = fifo_rd_word;

endmodule

// File: tb/tb_rr_fifo_wr_arbiter.sv
module tb_rr_fifo_wr_arbiter;

  localparam int unsigned ChNum = 4;
  localparam int unsigned Dw    = 8;
  localparam int unsigned Words = 16;
  localparam int unsigned Burst = 4;
  localparam int unsigned IdW   = 2;
  localparam int unsigned UsedW = $clog2(Words) + 1;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [ChNum-1:0]      ch_valid_i;
  logic [ChNum*Dw-1:0]   ch_data_i;
  logic [ChNum-1:0]      ch_ready_o;
  logic [ChNum-1:0]      grant_o;
  logic                  rd_i;
  logic [Dw-1:0]         rd_data_o;
  logic [IdW-1:0]        rd_ch_o;
  logic                  empty_o;
  logic                  full_o;
  logic [UsedW-1:0]      used_words_o;

  rr_fifo_wr_arbiter #(
    .CH_NUM       (ChNum),
    .DATA_WIDTH   (Dw),
    .WORDS_AMOUNT (Words),
    .BURST_LEN    (Burst)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ch_valid_i   (ch_valid_i),
    .ch_data_i    (ch_data_i),
    .ch_ready_o   (ch_ready_o),
    .grant_o      (grant_o),
    .rd_i         (rd_i),
    .rd_data_o    (rd_data_o),
    .rd_ch_o      (rd_ch_o),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .used_words_o (used_words_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  logic [IdW+Dw-1:0] exp_q[$];
  int wcnt [ChNum];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Channel c always presents data c*16 + (words it has delivered so far).
  task automatic drive_data();
    for (int c = 0; c < ChNum; c++) ch_data_i[c*Dw +: Dw] = 8'(c * 16 + wcnt[c]);
  endtask

  // One edge at which channel c is expected to transfer.
  task automatic xfer(input int c);
    exp_q.push_back({IdW'(c), 8'(c * 16 + wcnt[c])});
    step();
    wcnt[c]++;
    drive_data();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_grant"},   32'(grant_o), 0);
    chk({tag, "_ready"},   32'(ch_ready_o), 0);
    chk({tag, "_empty"},   32'(empty_o), 1);
    chk({tag, "_full"},    32'(full_o), 0);
    chk({tag, "_used"},    32'(used_words_o), 0);
    chk({tag, "_rd_data"}, 32'(rd_data_o), 0);
    chk({tag, "_rd_ch"},   32'(rd_ch_o), 0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (!empty_o && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_empty"}, 32'(empty_o), 1);
    chk({tag, "_used"},  32'(used_words_o), 0);
  endtask

  // Scoreboard monitor: every accepted pop must match the next expected word.
  always @(negedge clk_i) begin
    if (!rst_i && rd_i && !empty_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no word", {rd_ch_o, rd_data_o});
      end else begin
        chk("pop_word", 32'({rd_ch_o, rd_data_o}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i      = 1'b1;
    ch_valid_i = '0;
    rd_i       = 1'b0;
    ch_data_i  = '0;
    for (int c = 0; c < ChNum; c++) wcnt[c] = 0;
    drive_data();
    step();
    step();
    check_reset("rst");
    rst_i = 1'b0;

    // All channels request, no consumer: four full bursts then full.
    ch_valid_i = 4'b1111;
    chk("t1_idle_grant", 32'(grant_o), 0);
    step();
    for (int t = 0; t < 16; t++) begin
      chk("t1_ready", 32'(ch_ready_o), 1 << (t / 4));
      xfer(t / 4);
    end
    chk("t1_full",  32'(full_o), 1);
    chk("t1_used",  32'(used_words_o), 16);
    chk("t1_ready_full", 32'(ch_ready_o), 0);
    chk("t1_grant_held", 32'(grant_o), 'h1);
    chk("t1_empty", 32'(empty_o), 0);

    // Pop once without a write: full clears, owner ready returns.
    rd_i = 1'b1;
    step();
    rd_i = 1'b0;
    chk("t4_full_clear", 32'(full_o), 0);
    chk("t4_used15", 32'(used_words_o), 15);
    chk("t4_ready_back", 32'(ch_ready_o), 'h1);
    // One word of the burst, then full again mid-burst.
    xfer(0);
    chk("t4_full_again", 32'(full_o), 1);
    chk("t4_ready_off", 32'(ch_ready_o), 0);
    step();
    step();
    chk("t4_hold_grant", 32'(grant_o), 'h1);
    chk("t4_hold_used", 32'(used_words_o), 16);
    rd_i = 1'b1;
    step();
    chk("t4_full_clear2", 32'(full_o), 0);
    chk("t4_ready_back2", 32'(ch_ready_o), 'h1);
    // Three more words complete the burst only if the count held at one.
    for (int i = 0; i < 3; i++) begin
      xfer(0);
      chk("t5_used_const", 32'(used_words_o), 15);
      chk("t5_full_stable", 32'(full_o), 0);
      chk("t5_empty_stable", 32'(empty_o), 0);
    end
    chk("t4_next_grant", 32'(grant_o), 'h2);
    chk("t4_next_ready", 32'(ch_ready_o), 'h2);
    ch_valid_i = '0;
    drain("t1_drain");

    // Channel 2 streams alone while the consumer pops every cycle.
    ch_valid_i = 4'b0100;
    chk("t2_idle_grant", 32'(grant_o), 0);
    step();
    for (int t = 0; t < 10; t++) begin
      chk("t2_ready", 32'(ch_ready_o), 'h4);
      xfer(2);
      if (t == 0) chk("t2_latency_empty", 32'(empty_o), 1);
      if (t == 1) chk("t2_latency_data", 32'(empty_o), 0);
    end
    ch_valid_i = '0;
    drain("t2_drain");

    // Channel 1 drops valid after two words while channel 3 waits.
    ch_valid_i = 4'b0010;
    chk("t3_idle_grant", 32'(grant_o), 0);
    step();
    ch_valid_i = 4'b1010;
    chk("t3_ready1", 32'(ch_ready_o), 'h2);
    xfer(1);
    chk("t3_empty_after1", 32'(empty_o), 1);
    chk("t3_ready1b", 32'(ch_ready_o), 'h2);
    xfer(1);
    chk("t3_empty_after2", 32'(empty_o), 0);
    chk("t3_used2", 32'(used_words_o), 2);
    ch_valid_i = 4'b1000;
    chk("t3_idle_cycle_grant", 32'(grant_o), 'h2);
    step();
    chk("t3_grant3", 32'(grant_o), 'h8);
    chk("t3_ready3", 32'(ch_ready_o), 'h8);
    chk("t3_used1", 32'(used_words_o), 1);
    // Write plus pop with a single stored word: level and flags stay put.
    xfer(3);
    chk("t5_used1_a", 32'(used_words_o), 1);
    chk("t5_empty_a", 32'(empty_o), 0);
    xfer(3);
    chk("t5_used1_b", 32'(used_words_o), 1);
    chk("t5_empty_b", 32'(empty_o), 0);
    ch_valid_i = '0;
    step();
    chk("t3_end_empty", 32'(empty_o), 1);
    chk("t3_end_grant", 32'(grant_o), 0);
    rd_i = 1'b0;

    // Reset in the middle of a burst with five words stored.
    ch_valid_i = 4'b0001;
    step();
    for (int t = 0; t < 5; t++) begin
      chk("t6_ready", 32'(ch_ready_o), 'h1);
      step();
    end
    chk("t6_used5", 32'(used_words_o), 5);
    rst_i = 1'b1;
    #1;
    check_reset("t6_rst");
    step();
    rst_i      = 1'b0;
    ch_valid_i = 4'b1111;
    step();
    chk("t6_first_grant", 32'(grant_o), 'h1);
    ch_valid_i = '0;
    step();

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
